// File: rtl/game_pkg.sv
// Shared types and constants for the dinosaur-runner game controller.
package game_pkg;

  localparam int unsigned LIVES_W = 4;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] STATE_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] STATE_RUN   = 2'd1;
  localparam logic [STATE_W-1:0] STATE_PAUSE = 2'd2;
  localparam logic [STATE_W-1:0] STATE_OVER  = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_RUN   = STATE_RUN,
    ST_PAUSE = STATE_PAUSE,
    ST_OVER  = STATE_OVER
  } game_state_t;

endpackage

// File: rtl/frame_sync.sv
// Frame boundary detector: vs falling edge as a combinational strobe plus a
// registered one-cycle frame_tick on the edge that ends the boundary cycle.
module frame_sync (
  input  logic CLK,
  input  logic RESET_N,
  input  logic vs,
  output logic boundary_c,
  output logic frame_tick
);

  logic vs_d;

  assign boundary_c = vs_d & ~vs;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_d       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_d       <= vs;
      frame_tick <= boundary_c;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Frame-synchronised game state controller (IDLE/RUN/PAUSE/OVER, lives, score, speed).
// Define GAME_CTRL_PAUSE_EN to enable the PAUSE state; otherwise pause_btn is ignored.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES            = 3,
  parameter int unsigned SCORE_W          = 16,
  parameter int unsigned FRAMES_PER_POINT = 6,
  parameter int unsigned SCORE_STEP       = 100,
  parameter int unsigned SPEED_W          = 4,
  parameter int unsigned MAX_SPEED        = 15
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               vs,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               collide,
  output logic [1:0]         state,
  output logic               running,
  output logic               frame_tick,
  output logic [SCORE_W-1:0] score,
  output logic [SPEED_W-1:0] speed,
  output logic [LIVES_W-1:0] lives
);

  localparam int unsigned FC_W = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam int unsigned SC_W = (SCORE_STEP > 1) ? $clog2(SCORE_STEP) : 1;
  localparam logic [FC_W-1:0]    FC_LAST    = FC_W'(FRAMES_PER_POINT - 1);
  localparam logic [SC_W-1:0]    SC_LAST    = SC_W'(SCORE_STEP - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [SPEED_W-1:0] SPEED_MAX  = SPEED_W'(MAX_SPEED);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
`ifdef GAME_CTRL_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  game_state_t       state_r, state_nxt;
  logic              boundary_c;
  logic              start_d, pause_d;
  logic              start_pend, pause_pend, coll_pend;
  logic              start_pend_nxt, pause_pend_nxt, coll_pend_nxt;
  logic              start_ev_c, pause_ev_c, coll_ev_c;
  logic              running_nxt;
  logic [LIVES_W-1:0] lives_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [SPEED_W-1:0] speed_nxt;
  logic [FC_W-1:0]    frame_cnt, frame_cnt_nxt;
  logic [SC_W-1:0]    step_cnt, step_cnt_nxt;

  frame_sync u_frame_sync (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .vs         (vs),
    .boundary_c (boundary_c),
    .frame_tick (frame_tick)
  );

  assign state = state_r;

  // Events seen in the boundary cycle itself count at that boundary.
  assign start_ev_c = start_pend | (start_btn & ~start_d);
  assign pause_ev_c = pause_pend | (pause_btn & ~pause_d);
  assign coll_ev_c  = coll_pend | collide;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r    <= ST_IDLE;
      running    <= 1'b0;
      start_d    <= 1'b0;
      pause_d    <= 1'b0;
      start_pend <= 1'b0;
      pause_pend <= 1'b0;
      coll_pend  <= 1'b0;
      lives      <= LIVES_INIT;
      score      <= '0;
      speed      <= '0;
      frame_cnt  <= '0;
      step_cnt   <= '0;
    end else begin
      state_r    <= state_nxt;
      running    <= running_nxt;
      start_d    <= start_btn;
      pause_d    <= pause_btn;
      start_pend <= start_pend_nxt;
      pause_pend <= pause_pend_nxt;
      coll_pend  <= coll_pend_nxt;
      lives      <= lives_nxt;
      score      <= score_nxt;
      speed      <= speed_nxt;
      frame_cnt  <= frame_cnt_nxt;
      step_cnt   <= step_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state_r;
    start_pend_nxt = start_ev_c;
    pause_pend_nxt = pause_ev_c;
    coll_pend_nxt  = coll_ev_c;
    lives_nxt      = lives;
    score_nxt      = score;
    speed_nxt      = speed;
    frame_cnt_nxt  = frame_cnt;
    step_cnt_nxt   = step_cnt;

    if (boundary_c) begin
      start_pend_nxt = 1'b0;
      pause_pend_nxt = 1'b0;
      coll_pend_nxt  = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_ev_c) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (coll_ev_c) begin
            if (lives <= LIVES_W'(1)) begin
              state_nxt = ST_OVER;
              lives_nxt = '0;
            end else begin
              lives_nxt = lives - LIVES_W'(1);
            end
          end else if (PAUSE_EN && pause_ev_c) begin
            state_nxt = ST_PAUSE;
          end else if (frame_cnt == FC_LAST) begin
            frame_cnt_nxt = '0;
            // Step counter freezes once the score has saturated.
            if (score != SCORE_MAX) begin
              score_nxt = score + SCORE_W'(1);
              if (step_cnt == SC_LAST) begin
                step_cnt_nxt = '0;
                if (speed < SPEED_MAX) speed_nxt = speed + SPEED_W'(1);
              end else begin
                step_cnt_nxt = step_cnt + SC_W'(1);
              end
            end
          end else begin
            frame_cnt_nxt = frame_cnt + FC_W'(1);
          end
        end
        ST_PAUSE: begin
          if (pause_ev_c || start_ev_c) state_nxt = ST_RUN;
        end
        ST_OVER: begin
          if (start_ev_c) begin
            state_nxt     = ST_RUN;
            score_nxt     = '0;
            speed_nxt     = '0;
            lives_nxt     = LIVES_INIT;
            frame_cnt_nxt = '0;
            step_cnt_nxt  = '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    running_nxt = (state_nxt == ST_RUN);
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed testbench for game_ctrl (LIVES=3, FRAMES_PER_POINT=4, SCORE_STEP=10, MAX_SPEED=7).
module tb_game_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        vs;
  logic        start_btn;
  logic        pause_btn;
  logic        collide;
  logic [1:0]  state;
  logic        running;
  logic        frame_tick;
  logic [15:0] score;
  logic [3:0]  speed;
  logic [3:0]  lives;

  int errors = 0;
  int checks = 0;

  game_ctrl #(
    .LIVES(3), .SCORE_W(16), .FRAMES_PER_POINT(4),
    .SCORE_STEP(10), .SPEED_W(4), .MAX_SPEED(7)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .vs(vs),
    .start_btn(start_btn), .pause_btn(pause_btn), .collide(collide),
    .state(state), .running(running), .frame_tick(frame_tick),
    .score(score), .speed(speed), .lives(lives)
  );

  always #5 CLK = ~CLK;

  task automatic frame();
    @(negedge CLK) vs = 1'b0;
    @(negedge CLK) vs = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic pulse_start();
    @(negedge CLK) start_btn = 1'b1;
    @(negedge CLK) start_btn = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pulse_pause();
    @(negedge CLK) pause_btn = 1'b1;
    @(negedge CLK) pause_btn = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pulse_collide();
    @(negedge CLK) collide = 1'b1;
    @(negedge CLK) collide = 1'b0;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; vs = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; collide = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%0b exp=0", running); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%0b exp=0", frame_tick); end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score got=%0d exp=0", score); end
    checks++; if (speed !== 4'd0) begin errors++; $display("FAIL reset_speed got=%0d exp=0", speed); end
    checks++; if (lives !== 4'd3) begin errors++; $display("FAIL reset_lives got=%0d exp=3", lives); end
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_start_timing();
    pulse_start();
    repeat (5) @(negedge CLK);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_midframe_state got=%0d exp=0", state); end
    vs = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_vs_low_state got=%0d exp=0", state); end
    @(negedge CLK);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_run_state got=%0d exp=1", state); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got=%0b exp=1", running); end
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL start_tick got=%0b exp=1", frame_tick); end
    vs = 1'b1;
    @(negedge CLK);
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL start_tick_pulse got=%0b exp=0", frame_tick); end
    @(negedge CLK);
  endtask

  task automatic test_scoring();
    frames(40);
    checks++; if (score !== 16'd10) begin errors++; $display("FAIL score_40 got=%0d exp=10", score); end
    checks++; if (speed !== 4'd1) begin errors++; $display("FAIL speed_40 got=%0d exp=1", speed); end
    frames(240);
    checks++; if (score !== 16'd70) begin errors++; $display("FAIL score_280 got=%0d exp=70", score); end
    checks++; if (speed !== 4'd7) begin errors++; $display("FAIL speed_280 got=%0d exp=7", speed); end
    frames(40);
    checks++; if (score !== 16'd80) begin errors++; $display("FAIL score_320 got=%0d exp=80", score); end
    checks++; if (speed !== 4'd7) begin errors++; $display("FAIL speed_sat_320 got=%0d exp=7", speed); end
  endtask

  task automatic test_lives_to_over();
    pulse_collide(); frame();
    checks++; if (lives !== 4'd2) begin errors++; $display("FAIL lives_first got=%0d exp=2", lives); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL lives_first_state got=%0d exp=1", state); end
    pulse_collide(); frame();
    checks++; if (lives !== 4'd1) begin errors++; $display("FAIL lives_second got=%0d exp=1", lives); end
    // Third collision lands in the boundary cycle itself.
    @(negedge CLK) begin vs = 1'b0; collide = 1'b1; end
    @(negedge CLK) begin vs = 1'b1; collide = 1'b0; end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL over_state got=%0d exp=3", state); end
    checks++; if (lives !== 4'd0) begin errors++; $display("FAIL over_lives got=%0d exp=0", lives); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL over_running got=%0b exp=0", running); end
    repeat (2) @(negedge CLK);
    frames(10);
    checks++; if (score !== 16'd80) begin errors++; $display("FAIL over_score_frozen got=%0d exp=80", score); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL over_state_hold got=%0d exp=3", state); end
  endtask

  task automatic test_restart();
    pulse_start(); frame();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL restart_state got=%0d exp=1", state); end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL restart_score got=%0d exp=0", score); end
    checks++; if (speed !== 4'd0) begin errors++; $display("FAIL restart_speed got=%0d exp=0", speed); end
    checks++; if (lives !== 4'd3) begin errors++; $display("FAIL restart_lives got=%0d exp=3", lives); end
  endtask

  task automatic test_simultaneous();
    pulse_collide(); frame();
    checks++; if (lives !== 4'd2) begin errors++; $display("FAIL sim_lives_pre got=%0d exp=2", lives); end
    @(negedge CLK) begin pause_btn = 1'b1; collide = 1'b1; end
    @(negedge CLK) begin pause_btn = 1'b0; collide = 1'b0; end
    @(negedge CLK);
    frame();
    checks++; if (lives !== 4'd1) begin errors++; $display("FAIL sim_lives got=%0d exp=1", lives); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL sim_state got=%0d exp=1", state); end
    pulse_pause(); frame();
    frames(8);
`ifdef GAME_CTRL_PAUSE_EN
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_state got=%0d exp=2", state); end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL pause_score got=%0d exp=0", score); end
    pulse_start(); frame();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL resume_state got=%0d exp=1", state); end
`else
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL nopause_state got=%0d exp=1", state); end
    checks++; if (score !== 16'd2) begin errors++; $display("FAIL nopause_score got=%0d exp=2", score); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start(); frame();
    frames(148);
    checks++; if (score !== 16'd37) begin errors++; $display("FAIL mid_score_pre got=%0d exp=37", score); end
    checks++; if (speed !== 4'd3) begin errors++; $display("FAIL mid_speed_pre got=%0d exp=3", speed); end
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_state got=%0d exp=0", state); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL mid_running got=%0b exp=0", running); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL mid_tick got=%0b exp=0", frame_tick); end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL mid_score got=%0d exp=0", score); end
    checks++; if (speed !== 4'd0) begin errors++; $display("FAIL mid_speed got=%0d exp=0", speed); end
    checks++; if (lives !== 4'd3) begin errors++; $display("FAIL mid_lives got=%0d exp=3", lives); end
    @(negedge CLK) RESET_N = 1'b1;
    @(negedge CLK);
    pulse_start(); frame();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL post_reset_state got=%0d exp=1", state); end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL post_reset_score got=%0d exp=0", score); end
    checks++; if (lives !== 4'd3) begin errors++; $display("FAIL post_reset_lives got=%0d exp=3", lives); end
  endtask

  initial begin
    test_reset();
    test_start_timing();
    test_scoring();
    test_lives_to_over();
    test_restart();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
